// File: rtl/exp3_gravador_sequencia.sv
// Sequence recorder: waits for iniciar, writes each one-hot key press to consecutive RAM
// addresses and pulses pronto after N_JOGADAS entries. Define GRAVADOR_TIMEOUT_EN for the idle timeout.
module exp3_gravador_sequencia #(
   parameter int N_JOGADAS      = 16,
   parameter int TIMEOUT_CICLOS = 3000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [3:0] chaves,
   output logic       escreve,
   output logic [3:0] endereco,
   output logic [3:0] dado,
   output logic       pronto,
   output logic       timeout,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      INICIAL       = 4'h0,
      PREPARACAO    = 4'h1,
      ESPERA_JOGADA = 4'h2,
      REGISTRA      = 4'h4,
      GRAVA         = 4'h5,
      PROXIMO       = 4'h6,
      ESPERA_SOLTA  = 4'h7,
      FIM           = 4'hF
   } estado_t;

   localparam logic [3:0] ULTIMO = 4'(N_JOGADAS - 1);

   estado_t    estado_q, estado_d;
   logic [3:0] cont_q, cont_d;
   logic [3:0] reg_q, reg_d;
   logic       um_quente;

   assign um_quente = (chaves != 4'd0) && ((chaves & (chaves - 4'd1)) == 4'd0);

`ifdef GRAVADOR_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS + 1) : 1;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          to_q, to_d;
   logic          esgotado;

   // Last idle cycle is the one that sees 1, so exactly TIMEOUT_CICLOS cycles are spent waiting.
   assign esgotado = (tmr_q <= TW'(1));

   always_ff @(posedge clock) begin
      if (!reset) begin
         tmr_q <= '0;
         to_q  <= 1'b0;
      end else begin
         tmr_q <= tmr_d;
         to_q  <= to_d;
      end
   end
   assign timeout = to_q;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         estado_q <= INICIAL;
         cont_q   <= 4'd0;
         reg_q    <= 4'd0;
      end else begin
         estado_q <= estado_d;
         cont_q   <= cont_d;
         reg_q    <= reg_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      cont_d   = cont_q;
      reg_d    = reg_q;
`ifdef GRAVADOR_TIMEOUT_EN
      tmr_d    = tmr_q;
      to_d     = 1'b0;
`endif
      case (estado_q)
         INICIAL:    if (iniciar) estado_d = PREPARACAO;
         PREPARACAO: begin
            cont_d   = 4'd0;
            reg_d    = 4'd0;
            estado_d = ESPERA_JOGADA;
`ifdef GRAVADOR_TIMEOUT_EN
            tmr_d    = TW'(TIMEOUT_CICLOS);
`endif
         end
         ESPERA_JOGADA: begin
            if (um_quente) estado_d = REGISTRA;
`ifdef GRAVADOR_TIMEOUT_EN
            else if (esgotado) begin
               estado_d = FIM;
               to_d     = 1'b1;
            end else tmr_d = tmr_q - TW'(1);
`endif
         end
         REGISTRA: begin
            reg_d    = chaves;
            estado_d = GRAVA;
         end
         GRAVA:      estado_d = (cont_q == ULTIMO) ? FIM : PROXIMO;
         PROXIMO: begin
            cont_d   = cont_q + 4'd1;
            estado_d = ESPERA_SOLTA;
         end
         // A held key must be released before the next play is accepted.
         ESPERA_SOLTA: begin
            if (chaves == 4'd0) begin
               estado_d = ESPERA_JOGADA;
`ifdef GRAVADOR_TIMEOUT_EN
               tmr_d    = TW'(TIMEOUT_CICLOS);
`endif
            end
         end
         FIM:        estado_d = INICIAL;
         default:    estado_d = INICIAL;
      endcase
   end

   assign escreve  = (estado_q == GRAVA);
   assign pronto   = (estado_q == FIM);
   assign endereco = cont_q;
   assign dado     = reg_q;

   always_comb begin
      case (estado_q)
         INICIAL, PREPARACAO, ESPERA_JOGADA, REGISTRA,
         GRAVA, PROXIMO, ESPERA_SOLTA, FIM: db_estado = estado_q;
         default:                           db_estado = 4'hE;
      endcase
   end

endmodule

// File: tb/tb_exp3_gravador_sequencia.sv
// Bench for exp3_gravador_sequencia (N_JOGADAS=4, TIMEOUT_CICLOS=10): write scoreboard,
// per-cycle pronto model and directed state/timing checks.
module tb_exp3_gravador_sequencia;
   localparam int N = 4;

   logic       clock = 1'b0;
   logic       reset, iniciar;
   logic [3:0] chaves;
   logic       escreve, pronto, timeout;
   logic [3:0] endereco, dado, db_estado;

   int n_pass = 0;
   int n_total = 0;

   logic [7:0] exp_q[$];
   logic       chk_en = 1'b0;
   logic       chk_pronto = 1'b1;
   logic       pronto_pred = 1'b0;
   int         wcnt = 0;
   int         n_writes = 0;

   exp3_gravador_sequencia #(.N_JOGADAS(N), .TIMEOUT_CICLOS(10)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
      .escreve(escreve), .endereco(endereco), .dado(dado), .pronto(pronto),
      .timeout(timeout), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Inputs change 2 time units after a rising edge; outputs read then reflect that edge.
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   task automatic st(input string nm, input logic [3:0] e);
      chk(nm, db_estado, e);
   endtask

   // Scoreboard and pronto model, evaluated at every falling edge.
   always @(negedge clock) begin
      if (chk_en) begin
         if (escreve) begin
            n_writes++;
            if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
            else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               chk("write_addr", endereco, e[7:4]);
               chk("write_data", dado, e[3:0]);
            end
         end
         if (chk_pronto) chk("pronto_model", pronto, pronto_pred);
`ifndef GRAVADOR_TIMEOUT_EN
         chk("timeout_zero", timeout, 0);
`endif
         if (pronto) wcnt = 0;
         pronto_pred = reset && escreve && (wcnt + 1 == N);
         if (!reset) wcnt = 0;
         else if (escreve) wcnt = wcnt + 1;
      end
   end

   task automatic start_session();
      iniciar = 1'b1; step(); st("st_preparacao", 4'h1);
      iniciar = 1'b0; step(); st("st_espera", 4'h2);
   endtask

   task automatic pulse_reset();
      reset = 1'b0; step();
      reset = 1'b1;
   endtask

   initial begin
      logic [3:0] keys[4];
      int w0;
      keys[0] = 4'b0001; keys[1] = 4'b0010; keys[2] = 4'b0100; keys[3] = 4'b1000;
      reset = 1'b0; iniciar = 1'b0; chaves = 4'd0;
      step(2);
      chk_en = 1'b1;
      chk("rst_escreve", escreve, 0);
      chk("rst_pronto", pronto, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_endereco", endereco, 0);
      chk("rst_dado", dado, 0);
      st("rst_estado", 4'h0);
      reset = 1'b1;
      step(3);
      st("idle_stays_0", 4'h0);

      // Full session of 4 entries.
      w0 = n_writes;
      for (int i = 0; i < N; i++) exp_q.push_back({4'(i), keys[i]});
      start_session();
      for (int i = 0; i < N; i++) begin
         chaves = keys[i];
         step(); st("st_registra", 4'h4);
         step(); st("st_grava", 4'h5);
         chk("grava_escreve", escreve, 1);
         chk("grava_endereco", endereco, 4'(i));
         chk("grava_dado", dado, keys[i]);
         step();
         if (i == N - 1) begin
            st("st_fim", 4'hF);
            chk("fim_pronto", pronto, 1);
         end else st("st_proximo", 4'h6);
         chaves = 4'd0;
         step(); st("after_release1", (i == N - 1) ? 4'h0 : 4'h7);
         step(); st("after_release2", (i == N - 1) ? 4'h0 : 4'h2);
      end
      chk("session_writes", n_writes - w0, 4);
      chk("session_queue_empty", exp_q.size(), 0);
      iniciar = 1'b0;
      step(2);
      st("no_restart", 4'h0);

      // Invalid key is ignored, then a valid one is written at address 0.
      start_session();
      w0 = n_writes;
      chaves = 4'b0011;
      for (int c = 0; c < 5; c++) begin
         step(); st("invalid_stays_2", 4'h2);
      end
      chk("invalid_no_write", n_writes - w0, 0);
      chaves = 4'd0; step(); st("zero_stays_2", 4'h2);
      exp_q.push_back({4'd0, 4'b0100});
      chaves = 4'b0100; step(3);
      chaves = 4'd0; step(2); st("after_valid", 4'h2);
      chk("invalid_then_one_write", n_writes - w0, 1);

      // Held key recorded once.
      pulse_reset();
      start_session();
      w0 = n_writes;
      exp_q.push_back({4'd0, 4'b0010});
      chaves = 4'b0010; step(20);
      st("held_waits_7", 4'h7);
      chk("held_single_write", n_writes - w0, 1);
      chaves = 4'd0; step(); st("held_release", 4'h2);

      // Second write, then reset while in state 7.
      exp_q.push_back({4'd1, 4'b0001});
      chaves = 4'b0001; step(3);
      chaves = 4'd0; step();
      st("mid_in_7", 4'h7);
      chk("mid_endereco_2", endereco, 2);
      reset = 1'b0; step();
      st("mid_rst_estado", 4'h0);
      chk("mid_rst_endereco", endereco, 0);
      chk("mid_rst_dado", dado, 0);
      chk("mid_rst_escreve", escreve, 0);
      reset = 1'b1;
      start_session();
      exp_q.push_back({4'd0, 4'b1000});
      chaves = 4'b1000; step(2);
      chk("restart_addr0", endereco, 0);
      chk("restart_escreve", escreve, 1);
      step(); chaves = 4'd0; step(2);
      st("restart_back_2", 4'h2);

      // Idle in state 2: waits forever without the timeout, ends in F with it.
`ifdef GRAVADOR_TIMEOUT_EN
      pulse_reset();
      chk_pronto = 1'b0;
      start_session();
      step(9); st("to_still_2", 4'h2);
      step(); st("to_fim", 4'hF);
      chk("to_timeout", timeout, 1);
      chk("to_pronto", pronto, 1);
      step(); st("to_back_0", 4'h0);
      chk("to_cleared", timeout, 0);
      chk_pronto = 1'b1;
`else
      step(15);
      st("no_to_stays_2", 4'h2);
      chk("no_to_timeout", timeout, 0);
`endif
      chk("final_queue_empty", exp_q.size(), 0);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/exp3_gravador_sequencia.md
# exp3_gravador_sequencia

Control unit plus minimal datapath that records a player-entered sequence into the sequence RAM used by the game's comparison unit. It waits for `iniciar`, captures each one-hot key press on `chaves`, issues a single-cycle write of that value to consecutive RAM addresses starting at 0, and signals `pronto` after `N_JOGADAS` entries. It is the writer counterpart of the comparison/readout control unit: it fills the memory that the comparator later reads and checks.

## Interface
- `N_JOGADAS`, 16: number of entries recorded per session; legal range 1..16.
- `TIMEOUT_CICLOS`, 3000: idle cycles allowed in `espera_jogada`; used only with `GRAVADOR_TIMEOUT_EN`.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low; 0 at a rising edge forces reset.
- `iniciar`  in  1  starts a recording session; sampled only in `inicial`.
- `chaves`  in  4  player keys; a valid play is exactly one bit set.
- `escreve`  out  1  RAM write enable; 1 for exactly one cycle per recorded entry.
- `endereco`  out  4  RAM address, equal to the entry counter.
- `dado`  out  4  RAM write data, equal to the captured-key register.
- `pronto`  out  1  1 for exactly one cycle, in state `fim`.
- `timeout`  out  1  1 in `fim` when the session ended by timeout; otherwise 0.
- `db_estado`  out  4  state code, for debug.

## Operation
- State codes:
  - `inicial` 0
  - `preparacao` 1
  - `espera_jogada` 2
  - `registra` 4
  - `grava` 5
  - `proximo` 6
  - `espera_solta` 7
  - `fim` F
  - any illegal code shows E on `db_estado` and returns to `inicial`.
- Transitions:
  - `inicial` → `preparacao` if `iniciar`, else stay.
  - `preparacao` → `espera_jogada`; clears the counter and the register.
  - `espera_jogada` → `registra` if `chaves` is one-hot.
    - `chaves` all-zero or with more than one bit set: stay, nothing captured.
  - `registra` → `grava`; latches `chaves` into the register.
  - `grava` → `fim` if counter == `N_JOGADAS`-1, else → `proximo`.
  - `proximo` → `espera_solta`; counter increments by 1.
  - `espera_solta` → `espera_jogada` when `chaves` == 0.
    - A held key is therefore recorded only once.
  - `fim` → `inicial` unconditionally.
- Moore outputs:
  - `escreve` = 1 only in `grava`.
  - `pronto` = 1 only in `fim`.
  - `endereco` and `dado` are driven continuously from the counter and register.
- Counter is 4 bits and never wraps: `grava` exits to `fim` at `N_JOGADAS`-1. With `N_JOGADAS`=16 the last address is F.
- Reset (`reset`=0 at an edge), including mid-session:
  - state goes to `inicial`, counter to 0, register to 0.
  - next-cycle outputs: `escreve`=0, `pronto`=0, `timeout`=0, `endereco`=0, `dado`=0, `db_estado`=0.
  - RAM entries already written are left untouched.
- `iniciar` asserted outside `inicial` is ignored.

## Timing
- `iniciar`=1 sampled at edge k → `preparacao` at k+1, `espera_jogada` at k+2.
- Valid one-hot `chaves` sampled at edge j:
  - `registra` at j+1.
  - `grava` at j+2: `escreve`=1 with `endereco` = current count and `dado` = key.
  - `proximo` at j+3, `espera_solta` at j+4.
- Minimum spacing between two writes is 6 cycles, including one cycle with `chaves`=0.
- Last entry: `grava` at j+2, `fim` at j+3 (`pronto`=1), `inicial` at j+4.
- Data and address are stable for the whole `grava` cycle; the RAM writes on the following edge.

## Configuration
- `GRAVADOR_TIMEOUT_EN` defined:
  - A down-counter loads `TIMEOUT_CICLOS` on every entry to `espera_jogada`.
  - It decrements while in `espera_jogada`.
  - At zero the FSM goes → `fim` with `timeout`=1 and `pronto`=1.
  - The counter is cleared by reset.
- Not defined:
  - No timeout counter is generated; `timeout` is tied to 0.
  - `espera_jogada` waits indefinitely.

## Test plan
- Reset: `reset`=0 for 2 cycles from an arbitrary state → all outputs 0, `db_estado`=0; with `reset`=1 and `iniciar`=0 the FSM stays in 0.
- Full session, `N_JOGADAS`=4:
  - Stimulus: pulse `iniciar`, then `chaves` 0001, 0010, 0100, 1000, each held 3 cycles with 2 release cycles between.
  - Response: exactly 4 `escreve` pulses with (endereco, dado) = (0,1), (1,2), (2,4), (3,8).
  - Then `pronto`=1 for one cycle in F, then state 0.
- Invalid key: in state 2, `chaves`=0011 held 5 cycles → no write and state stays 2; then 0000 followed by 0100 → write (0,4).
- Held key: 0010 held 20 cycles → a single write (0,2); the FSM waits in 7 until `chaves`=0.
- Mid-session reset: `reset`=0 in state 7 after 2 writes → state 0 next cycle, `endereco`=0; a new session writes again from address 0.
- Timeout, macro defined, `TIMEOUT_CICLOS`=10: no key after entering state 2 → F after 10 cycles with `timeout`=1 and `pronto`=1. Same stimulus without the macro → remains in 2 and `timeout`=0.
